// File: rtl/gol_pkg.sv
// Shared timing constants and types for the Game of Life generation logic.
// Cells import this package so their advance compare matches the controller.
package gol_pkg;

   localparam int FRAMES_MAX = 199;
   localparam int SPEED_STEP = 50;

   typedef logic [1:0] speed_t;
   typedef logic [8:0] frame_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PAUSE = 2'd1,
      ST_STEP  = 2'd2
   } run_state_t;

   // Last frame index of a generation period: 199/149/99/49 for speed 0..3.
   function automatic frame_t thr_of(speed_t spd);
      return frame_t'(FRAMES_MAX - SPEED_STEP * int'(spd));
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus a third stage, producing a registered one-cycle
// pulse on each rising edge of an asynchronous level input.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_pulse
);

   logic r_s1, r_s2, r_s3;
   logic r_v1, r_v2;
   logic r_armed;
   logic r_pulse;

   // r_armed stays low until a genuine low sample has passed through r_s2, so
   // a level already high when reset is released does not count as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_armed <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_s1    <= i_d;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         r_v1    <= 1'b1;
         r_v2    <= r_v1;
         r_armed <= r_armed | (r_v2 & ~r_s2);
         r_pulse <= r_s2 & ~r_s3 & r_armed;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/gen_tick_ctrl.sv
// Generation-timing controller: frame counter, frame strobe and speed select
// broadcast to every cell, with pause, single-step and a generation counter.
//
// state    | meaning
// ST_RUN   | running; frame strobes advance fcnt and reach the cells
// ST_PAUSE | paused; fcnt frozen, edgeDet held low
// ST_STEP  | paused with one generation step waiting for the next strobe
module gen_tick_ctrl
   import gol_pkg::*;
#(
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vsync,
   input  logic             btn_fast,
   input  logic             btn_slow,
   input  logic             btn_pause,
   input  logic             btn_step,
   output logic [8:0]       vsync_edge,
   output logic             edgeDet,
   output logic [1:0]       speedCounter,
   output logic             gen_tick,
   output logic [GEN_W-1:0] gen_count,
   output logic             paused
);

   logic w_strobe, w_fast, w_slow, w_pause, w_step;

   sync_edge u_sync_vsync (.clk(clk), .rst(rst), .i_d(vsync),     .o_pulse(w_strobe));
   sync_edge u_sync_fast  (.clk(clk), .rst(rst), .i_d(btn_fast),  .o_pulse(w_fast));
   sync_edge u_sync_slow  (.clk(clk), .rst(rst), .i_d(btn_slow),  .o_pulse(w_slow));
   sync_edge u_sync_pause (.clk(clk), .rst(rst), .i_d(btn_pause), .o_pulse(w_pause));
   sync_edge u_sync_step  (.clk(clk), .rst(rst), .i_d(btn_step),  .o_pulse(w_step));

   run_state_t       r_state, w_state_nxt;
   frame_t           r_fcnt, w_fcnt_nxt;
   speed_t           r_speed, w_speed_nxt;
   logic [GEN_W-1:0] r_gen_count;

   frame_t w_thr, w_vsync_edge;
   logic   w_paused, w_step_pend, w_edge, w_gen_tick, w_spd_chg;

   assign w_thr       = thr_of(r_speed);
   assign w_paused    = (r_state != ST_RUN);
   assign w_step_pend = (r_state == ST_STEP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_fcnt      <= '0;
         r_speed     <= '0;
         r_gen_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_speed <= w_speed_nxt;
         if (w_gen_tick) begin
            r_gen_count <= r_gen_count + GEN_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_pause) w_state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (w_pause)     w_state_nxt = ST_RUN;
            else if (w_step) w_state_nxt = ST_STEP;
         end
         ST_STEP: begin
            if (w_pause)       w_state_nxt = ST_RUN;
            else if (w_strobe) w_state_nxt = ST_PAUSE;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // A speed change restarts the period so fcnt can never exceed the new threshold.
   always_comb begin
      w_speed_nxt = r_speed;
      w_spd_chg   = 1'b0;
      if (w_fast && !w_slow && r_speed != 2'd3) begin
         w_speed_nxt = r_speed + 2'd1;
         w_spd_chg   = 1'b1;
      end else if (w_slow && !w_fast && r_speed != 2'd0) begin
         w_speed_nxt = r_speed - 2'd1;
         w_spd_chg   = 1'b1;
      end

      w_fcnt_nxt = r_fcnt;
      if (w_spd_chg) begin
         w_fcnt_nxt = '0;
      end else if (w_strobe && !w_paused) begin
         w_fcnt_nxt = (r_fcnt == w_thr) ? '0 : r_fcnt + 9'd1;
      end
   end

   // A pending step presents the threshold so every cell advances exactly once.
   assign w_vsync_edge = w_step_pend ? w_thr : r_fcnt;
   assign w_edge       = w_strobe & (~w_paused | w_step_pend);
   assign w_gen_tick   = w_edge & (w_vsync_edge == w_thr);

   assign vsync_edge   = w_vsync_edge;
   assign edgeDet      = w_edge;
   assign speedCounter = r_speed;
   assign gen_tick     = w_gen_tick;
   assign gen_count    = r_gen_count;
   assign paused       = w_paused;

endmodule

// File: tb/tb_gen_tick_ctrl.sv
// Self-checking bench for gen_tick_ctrl: a reference model predicts every frame
// strobe into a scoreboard queue; button sequences are checked from a vector table.
module tb_gen_tick_ctrl;

   localparam int GEN_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             vsync = 1'b0;
   logic             btn_fast = 1'b0;
   logic             btn_slow = 1'b0;
   logic             btn_pause = 1'b0;
   logic             btn_step = 1'b0;
   logic [8:0]       vsync_edge;
   logic             edgeDet;
   logic [1:0]       speedCounter;
   logic             gen_tick;
   logic [GEN_W-1:0] gen_count;
   logic             paused;

   gen_tick_ctrl #(.GEN_W(GEN_W)) dut (
      .clk(clk), .rst(rst), .vsync(vsync),
      .btn_fast(btn_fast), .btn_slow(btn_slow), .btn_pause(btn_pause), .btn_step(btn_step),
      .vsync_edge(vsync_edge), .edgeDet(edgeDet), .speedCounter(speedCounter),
      .gen_tick(gen_tick), .gen_count(gen_count), .paused(paused)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct { int cyc; int ved; bit tick; int gc; } exp_t;
   exp_t sb_q[$];
   exp_t sb_e;

   // field order: vsyncs before press, fast, slow, pause, step, speed, paused, vsync_edge, gen_count
   typedef struct { int n_vs; bit f; bit s; bit p; bit st; int e_spd; int e_pau; int e_ved; int e_gc; } vec_t;
   vec_t tbl[10];

   int m_fcnt = 0, m_spd = 0, m_gc = 0;
   bit m_pau = 0, m_stp = 0;

   function automatic int m_thr();
      return 199 - 50 * m_spd;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      m_fcnt = 0; m_spd = 0; m_gc = 0; m_pau = 0; m_stp = 0;
      sb_q.delete();
   endtask

   always @(negedge clk) begin
      if (edgeDet || gen_tick) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: edgeDet=%0d gen_tick=%0d vsync_edge=%0d at cycle %0d, none expected",
                     edgeDet, gen_tick, vsync_edge, cyc);
         end else begin
            sb_e = sb_q.pop_front();
            chk("strobe_cycle", cyc, sb_e.cyc);
            chk("strobe_edgeDet", int'(edgeDet), 1);
            chk("strobe_vsync_edge", int'(vsync_edge), sb_e.ved);
            chk("strobe_gen_tick", int'(gen_tick), int'(sb_e.tick));
            chk("strobe_gen_count", int'(gen_count), sb_e.gc);
         end
      end
   end

   task automatic frame();
      exp_t e;
      bit   exp_edge;
      exp_edge = 1'b0;
      e.ved = 0;
      e.tick = 1'b0;
      if (m_pau) begin
         if (m_stp) begin
            exp_edge = 1'b1;
            e.ved    = m_thr();
            e.tick   = 1'b1;
            m_stp    = 1'b0;
         end
      end else begin
         exp_edge = 1'b1;
         e.ved    = m_fcnt;
         e.tick   = (m_fcnt == m_thr());
         m_fcnt   = e.tick ? 0 : m_fcnt + 1;
      end
      e.gc  = m_gc;
      e.cyc = cyc + 3;
      if (exp_edge) begin
         sb_q.push_back(e);
         if (e.tick) m_gc = (m_gc + 1) % 65536;
      end
      vsync = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      if (exp_edge) chk("strobe_seen", sb_q.size(), 0);
      vsync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic press(bit f, bit s, bit p, bit st);
      if (f && !s && m_spd < 3) begin
         m_spd++;
         m_fcnt = 0;
      end else if (s && !f && m_spd > 0) begin
         m_spd--;
         m_fcnt = 0;
      end
      if (p) begin
         if (m_pau) begin
            m_pau = 1'b0;
            m_stp = 1'b0;
         end else begin
            m_pau = 1'b1;
         end
      end else if (st && m_pau) begin
         m_stp = 1'b1;
      end
      btn_fast = f; btn_slow = s; btn_pause = p; btn_step = st;
      repeat (4) @(posedge clk);
      #1;
      btn_fast = 1'b0; btn_slow = 1'b0; btn_pause = 1'b0; btn_step = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_model(string tag);
      chk({tag, "_speed"}, int'(speedCounter), m_spd);
      chk({tag, "_paused"}, int'(paused), int'(m_pau));
      chk({tag, "_vsync_edge"}, int'(vsync_edge), m_stp ? m_thr() : m_fcnt);
      chk({tag, "_gen_count"}, int'(gen_count), m_gc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{5,   1, 0, 0, 0, 1, 0, 0, 2};
      tbl[1] = '{3,   1, 0, 0, 0, 2, 0, 0, 2};
      tbl[2] = '{7,   1, 0, 0, 0, 3, 0, 0, 2};
      tbl[3] = '{4,   1, 0, 0, 0, 3, 0, 4, 2};
      tbl[4] = '{0,   1, 1, 0, 0, 3, 0, 4, 2};
      tbl[5] = '{0,   0, 0, 0, 1, 3, 0, 4, 2};
      tbl[6] = '{100, 0, 1, 0, 0, 2, 0, 0, 4};
      tbl[7] = '{0,   0, 1, 0, 0, 1, 0, 0, 4};
      tbl[8] = '{1,   0, 1, 0, 0, 0, 0, 0, 4};
      tbl[9] = '{2,   0, 1, 0, 0, 0, 0, 2, 4};

      #1;
      chk("reset_vsync_edge", int'(vsync_edge), 0);
      chk("reset_edgeDet", int'(edgeDet), 0);
      chk("reset_speed", int'(speedCounter), 0);
      chk("reset_gen_tick", int'(gen_tick), 0);
      chk("reset_gen_count", int'(gen_count), 0);
      chk("reset_paused", int'(paused), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      reset_model();
      repeat (5) @(posedge clk);
      #1;

      // speed 0: two full 200-frame generations
      for (int i = 0; i < 400; i++) frame();
      chk("gen_count_after_400", int'(gen_count), 2);
      chk("fcnt_after_400", int'(vsync_edge), 0);

      for (int i = 0; i < 10; i++) begin
         repeat (tbl[i].n_vs) frame();
         press(tbl[i].f, tbl[i].s, tbl[i].p, tbl[i].st);
         chk($sformatf("tbl%0d_speed", i), int'(speedCounter), tbl[i].e_spd);
         chk($sformatf("tbl%0d_paused", i), int'(paused), tbl[i].e_pau);
         chk($sformatf("tbl%0d_vsync_edge", i), int'(vsync_edge), tbl[i].e_ved);
         chk($sformatf("tbl%0d_gen_count", i), int'(gen_count), tbl[i].e_gc);
      end
      chk_model("after_table");

      // speed change mid-period restarts a full 150-frame period
      repeat (118) frame();
      chk("fcnt_at_120", int'(vsync_edge), 120);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fast_mid_speed", int'(speedCounter), 1);
      chk("fast_mid_fcnt", int'(vsync_edge), 0);
      repeat (149) frame();
      chk("gen_count_before_150", int'(gen_count), 4);
      frame();
      chk("gen_count_after_150", int'(gen_count), 5);

      // pause and single-step
      repeat (10) frame();
      press(1'b0, 1'b0, 1'b1, 1'b0);
      chk("pause_on", int'(paused), 1);
      chk("pause_fcnt", int'(vsync_edge), 10);
      repeat (50) frame();
      chk("paused_fcnt_frozen", int'(vsync_edge), 10);
      chk("paused_gen_count", int'(gen_count), 5);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      chk("step_pending_thr", int'(vsync_edge), 149);
      frame();
      chk("step_gen_count", int'(gen_count), 6);
      chk("step_fcnt_kept", int'(vsync_edge), 10);
      frame();
      chk("step_once_gen_count", int'(gen_count), 6);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      chk("unpause", int'(paused), 0);
      chk("unpause_clears_step", int'(vsync_edge), 10);
      frame();
      chk_model("after_pause");

      // asynchronous reset with vsync held high
      repeat (66) frame();
      chk("fcnt_at_77", int'(vsync_edge), 77);
      vsync = 1'b1;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_vsync_edge", int'(vsync_edge), 0);
      chk("async_rst_speed", int'(speedCounter), 0);
      chk("async_rst_gen_count", int'(gen_count), 0);
      chk("async_rst_paused", int'(paused), 0);
      chk("async_rst_edgeDet", int'(edgeDet), 0);
      chk("async_rst_gen_tick", int'(gen_tick), 0);
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_high_vsync_edge", int'(vsync_edge), 0);
      vsync = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      frame();
      chk("post_rst_first_frame", int'(vsync_edge), 1);
      chk_model("final");

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
